// File: rtl/clk_div_bank_if.sv
// Shared divider-programming port: one write strobe, channel select, ratio and
// high time, plus the write-rejected pulse returned by the divider bank.
interface clk_div_bank_if #(
  parameter int CH = 4,
  parameter int W  = 16,
  parameter int SW = (CH > 1) ? $clog2(CH) : 1
);
  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [W-1:0]  div_val;
  logic [W-1:0]  duty_val;
  logic          wr_err;

  modport master (output div_wr, div_sel, div_val, duty_val, input wr_err);
  modport slave  (input div_wr, div_sel, div_val, duty_val, output wr_err);
endinterface

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock-enable dividers. New ratio/high-time
// settings sit in a shadow copy and are only taken on at a period boundary.
module clk_div_bank #(
  parameter int CH      = 4,
  parameter int W       = 16,
  parameter int DEF_DIV = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   en,
  clk_div_bank_if.slave   wr_bus,
  output logic [CH-1:0]   pend,
  output logic [CH-1:0]   o_clk,
  output logic [CH-1:0]   o_tick
);

  localparam int SW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [W-1:0]  DEF_N = W'(DEF_DIV);
  localparam logic [W-1:0]  DEF_H = W'(DEF_DIV / 2);
  localparam logic [SW:0]   CH_L  = (SW + 1)'(CH);

  logic [CH-1:0][W-1:0] cnt_q, cnt_d;
  logic [CH-1:0][W-1:0] act_n_q, act_n_d, act_h_q, act_h_d;
  logic [CH-1:0][W-1:0] sh_n_q, sh_n_d, sh_h_q, sh_h_d;
  logic [CH-1:0]        pend_q, pend_d, o_clk_q, o_clk_d, o_tick_q, o_tick_d;
  logic                 wr_err_q, wr_err_d;
  logic                 wr_ok;
  logic [CH-1:0]        wr_hit, wrap;

  // A wrap and a write on the same edge: the wrap consumes the old shadow
  // while the new write lands in the shadow and stays pending.
  always_comb begin
    wr_ok    = (wr_bus.div_val >= W'(2)) && (wr_bus.duty_val <= wr_bus.div_val)
               && ({1'b0, wr_bus.div_sel} < CH_L);
    wr_err_d = wr_bus.div_wr && !wr_ok;
    cnt_d    = cnt_q;
    act_n_d  = act_n_q;
    act_h_d  = act_h_q;
    sh_n_d   = sh_n_q;
    sh_h_d   = sh_h_q;
    pend_d   = pend_q;
    o_clk_d  = '0;
    o_tick_d = '0;
    wr_hit   = '0;
    wrap     = '0;
    for (int i = 0; i < CH; i++) begin
      wr_hit[i] = wr_bus.div_wr && wr_ok && (wr_bus.div_sel == SW'(i));
      wrap[i]   = en[i] && (cnt_q[i] >= act_n_q[i] - W'(1));
      if (wrap[i] && pend_q[i]) begin
        act_n_d[i] = sh_n_q[i];
        act_h_d[i] = sh_h_q[i];
      end
      if (wr_hit[i]) begin
        sh_n_d[i] = wr_bus.div_val;
        sh_h_d[i] = wr_bus.duty_val;
      end
      pend_d[i] = wr_hit[i] || (pend_q[i] && !wrap[i]);
      if (!en[i])
        cnt_d[i] = act_n_q[i] - W'(1);
      else if (wrap[i])
        cnt_d[i] = '0;
      else
        cnt_d[i] = cnt_q[i] + W'(1);
      o_clk_d[i]  = en[i] && (cnt_d[i] >= act_n_d[i] - act_h_d[i]);
      o_tick_d[i] = wrap[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= {CH{DEF_N - W'(1)}};
      act_n_q  <= {CH{DEF_N}};
      act_h_q  <= {CH{DEF_H}};
      sh_n_q   <= {CH{DEF_N}};
      sh_h_q   <= {CH{DEF_H}};
      pend_q   <= '0;
      o_clk_q  <= '0;
      o_tick_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      act_n_q  <= act_n_d;
      act_h_q  <= act_h_d;
      sh_n_q   <= sh_n_d;
      sh_h_q   <= sh_h_d;
      pend_q   <= pend_d;
      o_clk_q  <= o_clk_d;
      o_tick_q <= o_tick_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign pend          = pend_q;
  assign o_clk         = o_clk_q;
  assign o_tick        = o_tick_q;
  assign wr_bus.wr_err = wr_err_q;

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a per-cycle vector table for the default
// ratio and write rejection, then hand-timed sequences for shadowing corners.
module tb_clk_div_bank;
  localparam int CH = 5;
  localparam int W  = 16;

  typedef struct {
    logic [CH-1:0] en;
    logic          wr;
    logic [2:0]    sel;
    logic [W-1:0]  n;
    logic [W-1:0]  h;
    logic [CH-1:0] e_clk;
    logic [CH-1:0] e_tick;
    logic [CH-1:0] e_pend;
    logic          e_err;
  } vec_t;

  logic          clk;
  logic          reset;
  logic [CH-1:0] en;
  logic [CH-1:0] pend, o_clk, o_tick;
  int            n_cmp = 0;
  int            n_bad = 0;
  vec_t          vecs [26];

  clk_div_bank_if #(.CH(CH), .W(W)) bus ();

  clk_div_bank #(.CH(CH), .W(W), .DEF_DIV(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .wr_bus (bus),
    .pend   (pend),
    .o_clk  (o_clk),
    .o_tick (o_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Runs until channel ch ticks, reporting cycles taken and o_clk high count.
  task automatic wait_tick(input int ch, input int budget, output int waited, output int highs);
    bit seen = 0;
    waited = 0;
    highs  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      waited++;
      if (o_clk[ch]) highs++;
      if (o_tick[ch]) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("[TB] FAIL tick_timeout ch%0d: got no tick, want one within %0d cycles", ch, budget);
    end
  endtask

  task automatic write_ch(input int sel, input int n, input int h);
    bus.div_wr   = 1'b1;
    bus.div_sel  = 3'(sel);
    bus.div_val  = W'(n);
    bus.duty_val = W'(h);
    cyc();
    bus.div_wr   = 1'b0;
    check($sformatf("wr_ok_err ch%0d", sel), 32'(bus.wr_err), 0);
    check($sformatf("wr_pend ch%0d", sel), 32'(pend[sel]), 1);
  endtask

  initial begin
    int w, hi;
    for (int k = 1; k <= 20; k++)
      vecs[k-1] = '{5'b00001, 1'b0, 3'd0, 16'd0, 16'd0,
                    (((k - 1) % 10) >= 5) ? 5'b00001 : 5'b00000,
                    (((k - 1) % 10) == 0) ? 5'b00001 : 5'b00000, 5'b0, 1'b0};
    vecs[20] = '{5'b00001, 1'b1, 3'd0, 16'd1, 16'd0, 5'b00000, 5'b00001, 5'b0, 1'b1};
    vecs[21] = '{5'b00001, 1'b0, 3'd0, 16'd0, 16'd0, 5'b00000, 5'b00000, 5'b0, 1'b0};
    vecs[22] = '{5'b00001, 1'b1, 3'd0, 16'd4, 16'd5, 5'b00000, 5'b00000, 5'b0, 1'b1};
    vecs[23] = '{5'b00001, 1'b0, 3'd0, 16'd0, 16'd0, 5'b00000, 5'b00000, 5'b0, 1'b0};
    vecs[24] = '{5'b00001, 1'b1, 3'd5, 16'd4, 16'd1, 5'b00000, 5'b00000, 5'b0, 1'b1};
    vecs[25] = '{5'b00001, 1'b0, 3'd0, 16'd0, 16'd0, 5'b00001, 5'b00000, 5'b0, 1'b0};

    reset = 1'b0;
    en = '0;
    bus.div_wr = 1'b0;
    bus.div_sel = '0;
    bus.div_val = '0;
    bus.duty_val = '0;
    cyc();
    cyc();
    check("rst_o_clk", 32'(o_clk), 0);
    check("rst_o_tick", 32'(o_tick), 0);
    check("rst_pend", 32'(pend), 0);
    check("rst_wr_err", 32'(bus.wr_err), 0);
    reset = 1'b1;

    // Default ratio on ch0 and rejected writes, cycle by cycle.
    for (int v = 0; v < 26; v++) begin
      en           = vecs[v].en;
      bus.div_wr   = vecs[v].wr;
      bus.div_sel  = vecs[v].sel;
      bus.div_val  = vecs[v].n;
      bus.duty_val = vecs[v].h;
      cyc();
      check($sformatf("vec%0d o_clk", v), 32'(o_clk), 32'(vecs[v].e_clk));
      check($sformatf("vec%0d o_tick", v), 32'(o_tick), 32'(vecs[v].e_tick));
      check($sformatf("vec%0d pend", v), 32'(pend), 32'(vecs[v].e_pend));
      check($sformatf("vec%0d wr_err", v), 32'(bus.wr_err), 32'(vecs[v].e_err));
    end
    bus.div_wr = 1'b0;

    // Minimum ratio N=2 with H=N on ch4.
    write_ch(4, 2, 2);
    en[4] = 1'b1;
    wait_tick(4, 4, w, hi);
    check("ch4_first_tick", 32'(w), 1);
    check("ch4_pend_clr", 32'(pend[4]), 0);
    wait_tick(4, 6, w, hi);
    check("ch4_period", 32'(w), 2);
    check("ch4_high", 32'(hi), 2);

    // ch0: N=4 H=1 written at cycle 3 of a 10-cycle period.
    wait_tick(0, 12, w, hi);
    cyc();
    cyc();
    write_ch(0, 4, 1);
    wait_tick(0, 12, w, hi);
    check("ch0_old_period_rest", 32'(w), 7);
    check("ch0_pend_clr", 32'(pend[0]), 0);
    for (int r = 0; r < 2; r++) begin
      wait_tick(0, 8, w, hi);
      check($sformatf("ch0_n4_period%0d", r), 32'(w), 4);
      check($sformatf("ch0_n4_high%0d", r), 32'(hi), 1);
    end

    // ch1: H=0 then H=N.
    write_ch(1, 6, 0);
    en[1] = 1'b1;
    wait_tick(1, 4, w, hi);
    check("ch1_first_tick", 32'(w), 1);
    check("ch1_pend_clr", 32'(pend[1]), 0);
    for (int r = 0; r < 2; r++) begin
      wait_tick(1, 10, w, hi);
      check($sformatf("ch1_h0_period%0d", r), 32'(w), 6);
      check($sformatf("ch1_h0_high%0d", r), 32'(hi), 0);
    end
    write_ch(1, 6, 6);
    wait_tick(1, 10, w, hi);
    check("ch1_switch_rest", 32'(w), 5);
    for (int r = 0; r < 2; r++) begin
      wait_tick(1, 10, w, hi);
      check($sformatf("ch1_h6_period%0d", r), 32'(w), 6);
      check($sformatf("ch1_h6_high%0d", r), 32'(hi), 6);
    end

    // ch2: pending N=8, then N=3 written exactly on the wrap edge.
    en[2] = 1'b1;
    wait_tick(2, 4, w, hi);
    check("ch2_first_tick", 32'(w), 1);
    write_ch(2, 8, 4);
    repeat (8) cyc();
    write_ch(2, 3, 1);
    check("ch2_wrap_on_write", 32'(o_tick[2]), 1);
    wait_tick(2, 12, w, hi);
    check("ch2_old_shadow_period", 32'(w), 8);
    check("ch2_old_shadow_high", 32'(hi), 4);
    check("ch2_pend_clr", 32'(pend[2]), 0);
    wait_tick(2, 12, w, hi);
    check("ch2_new_period", 32'(w), 3);
    check("ch2_new_high", 32'(hi), 1);

    // ch0: disable during the high phase, reprogram, re-enable.
    wait_tick(0, 8, w, hi);
    repeat (3) cyc();
    check("ch0_high_before_dis", 32'(o_clk[0]), 1);
    en[0] = 1'b0;
    cyc();
    check("ch0_dis_clk", 32'(o_clk[0]), 0);
    check("ch0_dis_tick", 32'(o_tick[0]), 0);
    write_ch(0, 5, 2);
    for (int r = 0; r < 3; r++) begin
      cyc();
      check($sformatf("ch0_idle_clk%0d", r), 32'(o_clk[0]), 0);
      check($sformatf("ch0_idle_tick%0d", r), 32'(o_tick[0]), 0);
    end
    en[0] = 1'b1;
    cyc();
    check("ch0_reen_tick", 32'(o_tick[0]), 1);
    check("ch0_reen_pend", 32'(pend[0]), 0);
    wait_tick(0, 10, w, hi);
    check("ch0_n5_period", 32'(w), 5);
    check("ch0_n5_high", 32'(hi), 2);

    // Asynchronous reset while ch1 is high, between clock edges.
    check("ch1_high_pre_rst", 32'(o_clk[1]), 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_o_clk", 32'(o_clk), 0);
    check("async_rst_pend", 32'(pend), 0);
    en = 5'b00001;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    check("post_rst_tick", 32'(o_tick), 32'(5'b00001));
    wait_tick(0, 14, w, hi);
    check("post_rst_period", 32'(w), 10);
    check("post_rst_high", 32'(hi), 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable divider. Each of `CH` independent channels divides the system clock by a runtime-programmable ratio with a programmable high time, and emits a registered square output plus a one-cycle period tick. It replaces the fixed single-ratio dividers in the timebase path (1 kHz → 100 Hz, display scan, debounce sampling). Ratio changes are shadowed and applied only at a period boundary, so outputs never glitch.

## Interface
- `CH`, 4, number of channels (1..16)
- `W`, 16, counter/ratio width in bits
- `DEF_DIV`, 10, reset divide ratio of every channel (2..2^W-1)
- `SW`, $clog2(CH) (min 1), width of `div_sel`

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `en`  in  CH  per-channel run enable
- `div_wr`  in  1  single-cycle write strobe
- `div_sel`  in  SW  channel index for write
- `div_val`  in  W  new divide ratio N
- `duty_val`  in  W  new high-time H, in clk cycles
- `wr_err`  out  1  one-cycle pulse: write rejected
- `pend`  out  CH  channel has an unapplied shadow setting
- `o_clk`  out  CH  divided clock output, registered
- `o_tick`  out  CH  one-cycle pulse at the start of each period

## Operation
- Per channel state: `cnt` (W), active `act_n`/`act_h`, shadow `sh_n`/`sh_h`, `pend`.
- Reset (async, `reset`=0): `cnt`=DEF_DIV-1, `act_n`=`sh_n`=DEF_DIV, `act_h`=`sh_h`=DEF_DIV/2 (floor), `pend`=0, `o_clk`=0, `o_tick`=0, `wr_err`=0.
- Write: on `div_wr`=1, accepted iff `div_sel`<CH, `div_val`>=2, `duty_val`<=`div_val`. Accept → `sh_n`/`sh_h` of that channel loaded, `pend` set next edge. Reject → no state change, `wr_err`=1 for exactly one cycle.
- Write while `pend`=1 overwrites shadow (last write wins).
- Running (`en`[i]=1): `cnt` increments; at `cnt`==`act_n`-1 it wraps to 0 (wrap edge). On the wrap edge, if `pend`, `act_n`/`act_h` load from shadow and `pend` clears.
- Write accepted on the same edge as a wrap does not apply on that wrap: it lands in shadow, applies at the following wrap; any previously pending value is applied on this wrap only if not overwritten — since the write overwrites shadow on that edge, the wrap loads the OLD shadow and the new one stays pending.
- `o_clk` after each edge = (`cnt` >= `act_n`-`act_h`), using post-edge `cnt` and active values. H=0 → constantly low; H=N → constantly high. Default N=10 → 5 low, 5 high.
- `o_tick` after each edge = 1 iff that edge was a wrap edge (post-edge `cnt`==0 with running channel).
- Disabled (`en`[i]=0): `cnt` forced to `act_n`-1, `o_clk`=0, `o_tick`=0; writes still accepted into shadow. First enabled edge is a wrap edge: tick fires, pending applied.
- Channels fully independent; `wr_err` and write port shared.
- Arithmetic: all compares unsigned W-bit; `act_n`-`act_h` never underflows (H<=N enforced).

## Timing
- Write-to-`pend`: 1 cycle. Write-to-effect: next wrap edge strictly after the write edge.
- `o_clk` and `o_tick` are flop outputs, no combinational path from any input.
- Period exactly `act_n` cycles; high exactly `act_h` cycles, ending with the cycle before the next tick.
- `en` falling: `o_clk` low after that edge. `en` rising: tick after that edge.
- Reset mid-period: outputs low immediately (async); after release, channels with `en`=1 tick on first edge.

## Test plan
- Reset, `en`=0001, no writes → ch0 `o_tick` every 10 cycles, `o_clk` 5 low then 5 high; ch1-3 `o_clk`/`o_tick` stay 0.
- Write ch0 N=4 H=1 at cycle 3 of a period → `pend`[0]=1; current period completes at 10 cycles; then period 4, `o_clk` high 1 cycle each period; `pend`[0] clears on that wrap.
- Writes N=1, H=5/N=4, `div_sel`=4 with CH=4 → `wr_err` one-cycle pulse each, no `pend`, outputs unchanged.
- ch1 N=6 H=0 then N=6 H=6 → `o_clk`[1] constantly 0 then constantly 1; `o_tick`[1] continues every 6 cycles.
- Write on the exact wrap edge (N=8 then N=3 two periods later timed to wrap) → new ratio takes effect one period later, verified by tick spacing.
- Drop `en`[0] mid-period, write N=5 while disabled, re-enable → `o_clk` 0 while disabled, tick on first enabled edge, subsequent period 5; async reset asserted mid-high → `o_clk` 0 without clock edge.
